// File: rtl/vga_font_loader_pkg.sv
// Shared widths, types and FSM encoding for the font memory writer.
package vga_font_loader_pkg;

    localparam int ADDR_WIDTH = 11;
    localparam int DATA_WIDTH = 8;
    localparam int ROW_BITS   = 4;
    localparam int CHAR_BITS  = ADDR_WIDTH - ROW_BITS;
    localparam int NUM_ROWS   = 1 << ROW_BITS;

    typedef logic [CHAR_BITS-1:0]  char_t;
    typedef logic [ROW_BITS-1:0]   row_t;
    typedef logic [0:DATA_WIDTH-1] pix_t;   // bit 0 = leftmost pixel
    typedef logic [ADDR_WIDTH-1:0] faddr_t;

    localparam row_t LAST_ROW = row_t'(NUM_ROWS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_WAIT_BLANK,
        ST_COMMIT
    } state_e;

    // Row index occupies the low bits so a glyph never carries into the next char.
    function automatic faddr_t font_addr(char_t c, row_t r);
        return {c, r};
    endfunction

endpackage

// File: rtl/vga_font_loader_if.sv
// Glyph upload channel from the tile: command (char code) then 16 rows, both valid/ready.
interface vga_font_loader_if;
    import vga_font_loader_pkg::*;

    logic  cmd_valid;
    char_t cmd_char;
    logic  cmd_ready;
    logic  row_valid;
    pix_t  row_data;
    logic  row_ready;

    modport master (
        output cmd_valid, cmd_char, row_valid, row_data,
        input  cmd_ready, row_ready
    );

    modport slave (
        input  cmd_valid, cmd_char, row_valid, row_data,
        output cmd_ready, row_ready
    );

endinterface

// File: rtl/vga_font_loader_glyph_buf.sv
// 16-row staging buffer: one synchronous write port, one combinational read port.
module vga_font_loader_glyph_buf
    import vga_font_loader_pkg::*;
(
    input  logic clk_i,
    input  logic we_i,
    input  row_t waddr_i,
    input  pix_t wdata_i,
    input  row_t raddr_i,
    output pix_t rdata_o
);

    pix_t mem_q [NUM_ROWS];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/vga_font_loader.sv
// Buffers a 16-row glyph upload, then commits it to font memory one row per cycle.
// FONTLD_BLANK_GATE_EN: when defined, commits only proceed while blank_i is high.
module vga_font_loader
    import vga_font_loader_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_i,
    vga_font_loader_if.slave       up,
    input  logic                   blank_i,
    output logic [ADDR_WIDTH-1:0]  addr_w_o,
    output logic                   wr_en_o,
    output pix_t                   din_o,
    output logic                   busy_o,
    output logic                   done_o
);

    state_e state_q;
    char_t  char_q;
    row_t   cnt_q;
    faddr_t addr_q;
    logic   wr_en_q;
    pix_t   din_q;
    logic   done_q;

    logic   cmd_hs;
    logic   row_hs;
    logic   commit_go;
    pix_t   buf_rdata;

`ifdef FONTLD_BLANK_GATE_EN
    // blank_i sampled in the cycle before the write lands, so a write trails blank by one cycle.
    assign commit_go = blank_i;
`else
    logic unused_blank;
    assign unused_blank = blank_i;
    assign commit_go    = 1'b1;
`endif

    assign up.cmd_ready = (state_q == ST_IDLE)    & ~rst_i;
    assign up.row_ready = (state_q == ST_COLLECT) & ~rst_i;

    assign cmd_hs = up.cmd_valid & up.cmd_ready;
    assign row_hs = up.row_valid & up.row_ready;

    vga_font_loader_glyph_buf u_buf (
        .clk_i   (clk_i),
        .we_i    (row_hs),
        .waddr_i (cnt_q),
        .wdata_i (up.row_data),
        .raddr_i (cnt_q),
        .rdata_o (buf_rdata)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            char_q  <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            wr_en_q <= 1'b0;
            din_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (cmd_hs) begin
                        char_q  <= up.cmd_char;
                        cnt_q   <= '0;
                        state_q <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (row_hs) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST_ROW) begin
                            state_q <= ST_WAIT_BLANK;
                        end
                    end
                end
                // Both states issue the next row when allowed; cnt_q survives a pause.
                ST_WAIT_BLANK, ST_COMMIT: begin
                    if (commit_go) begin
                        wr_en_q <= 1'b1;
                        addr_q  <= font_addr(char_q, cnt_q);
                        din_q   <= buf_rdata;
                        cnt_q   <= cnt_q + 1'b1;
                        if (cnt_q == LAST_ROW) begin
                            state_q <= ST_IDLE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_COMMIT;
                        end
                    end else begin
                        state_q <= ST_WAIT_BLANK;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign addr_w_o = addr_q;
    assign wr_en_o  = wr_en_q;
    assign din_o    = din_q;
    assign done_o   = done_q;
    assign busy_o   = (state_q != ST_IDLE);

endmodule
